// File: rtl/fetch_align_unit.sv
// -----------------------------------------------------------------------------
// fetch_align_unit
//   Instruction fetch and alignment stage feeding decode. Walks a 16-bit
//   granular PC, reads 32-bit words from the I-cache and assembles complete
//   RV32I / RV32C instructions, including 32-bit instructions that straddle
//   a word boundary. One instruction per valid/ready handshake.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   ICACHE_ren/addr     word read request (addr = byte address [31:2])
//   ICACHE_wen/wdata    unused write side, tied low
//   ICACHE_stall        cache busy; a read completes when ren=1 and stall=0
//   ICACHE_rdata        read data, byte-swapped relative to instruction order
//   redirect_valid/pc   one-cycle PC redirect from branch/jump resolution
//   out_valid/ready     handshake towards decode
//   out_instr/pc        instruction (zero-extended when compressed) and its PC
//   out_compressed      out_instr holds a 16-bit instruction
// -----------------------------------------------------------------------------
module fetch_align_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ICACHE_ren,
    output logic        ICACHE_wen,
    output logic [29:0] ICACHE_addr,
    output logic [31:0] ICACHE_wdata,
    input  logic        ICACHE_stall,
    input  logic [31:0] ICACHE_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_compressed
);

    // Architectural fetch state
    logic [31:0] r_pc;          // next PC to deliver
    logic [15:0] r_h;           // halfword at r_pc when r_h_vld and r_pc[1]
    logic        r_h_vld;
    logic [31:0] r_s;           // skid word, already byte-reordered
    logic        r_s_vld;

    // Output register
    logic        r_out_vld;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc;
    logic        r_out_comp;

    // Request control
    logic        r_run;         // low for one cycle after reset so ren starts at 0
    logic        r_hold;        // a stalled request is outstanding
    logic [29:0] r_hold_addr;
    logic        r_discard;     // outstanding request was overtaken by a redirect

    logic [31:0] w_rword;
    logic [31:0] w_word;
    logic        w_adv;
    logic        w_bufc;
    logic [31:0] w_pc_p2;
    logic [31:0] w_pc_p4;
    logic [29:0] w_need_addr;
    logic        w_ren_raw;
    logic        w_rd_use;
    logic        w_have;
    logic [31:0] w_redir_pc;

    logic [31:0] w_pc_n;
    logic [15:0] w_h_n;
    logic        w_hv_n;
    logic [31:0] w_s_n;
    logic        w_sv_n;
    logic        w_ov_n;
    logic [31:0] w_oi_n;
    logic [31:0] w_op_n;
    logic        w_oc_n;
    logic        w_hold_n;
    logic        w_discard_n;

    assign ICACHE_wen   = 1'b0;
    assign ICACHE_wdata = 32'h0;

    assign out_valid      = r_out_vld;
    assign out_instr      = r_out_instr;
    assign out_pc         = r_out_pc;
    assign out_compressed = r_out_comp;

    // Memory bytes arrive swapped; restore instruction order
    assign w_rword = {ICACHE_rdata[7:0], ICACHE_rdata[15:8],
                      ICACHE_rdata[23:16], ICACHE_rdata[31:24]};
    assign w_word  = r_s_vld ? r_s : w_rword;

    assign w_adv      = !r_out_vld || out_ready;
    assign w_pc_p2    = r_pc + 32'd2;
    assign w_pc_p4    = r_pc + 32'd4;
    assign w_redir_pc = redirect_pc & 32'hFFFF_FFFE;

    // A compressed halfword already sitting in H needs no memory access
    assign w_bufc = r_pc[1] && r_h_vld && (r_h[1:0] != 2'b11);

    // Straddle needs the word after H; aligned and post-redirect bubble need
    // the word containing r_pc
    assign w_need_addr = (r_pc[1] && r_h_vld) ? w_pc_p2[31:2] : r_pc[31:2];

    // Prefetch one word even under backpressure; the skid register absorbs it
    assign w_ren_raw = r_run && !r_s_vld && !w_bufc;

    // A stalled request keeps ren/addr frozen until the cache accepts it
    assign ICACHE_ren  = r_hold || w_ren_raw;
    assign ICACHE_addr = r_hold ? r_hold_addr : (w_ren_raw ? w_need_addr : 30'h0);

    assign w_rd_use = ICACHE_ren && !ICACHE_stall && !(r_hold && r_discard);
    assign w_have   = r_s_vld || w_rd_use;

    always_comb begin
        w_pc_n = r_pc;
        w_h_n  = r_h;
        w_hv_n = r_h_vld;
        w_s_n  = r_s;
        w_sv_n = r_s_vld;
        w_ov_n = r_out_vld;
        w_oi_n = r_out_instr;
        w_op_n = r_out_pc;
        w_oc_n = r_out_comp;

        if (w_adv) begin
            w_ov_n = 1'b0;
            if (w_bufc) begin
                w_ov_n = 1'b1;
                w_oi_n = {16'h0, r_h};
                w_op_n = r_pc;
                w_oc_n = 1'b1;
                w_pc_n = w_pc_p2;
                w_hv_n = 1'b0;
            end else if (w_have) begin
                w_sv_n = 1'b0;
                // Upper half always becomes the halfword at the new PC
                // (ignored after an aligned 32-bit instruction)
                w_h_n  = w_word[31:16];
                w_hv_n = 1'b1;
                if (!r_pc[1]) begin
                    w_ov_n = 1'b1;
                    w_op_n = r_pc;
                    if (w_word[1:0] == 2'b11) begin
                        w_oi_n = w_word;
                        w_oc_n = 1'b0;
                        w_pc_n = w_pc_p4;
                        w_hv_n = 1'b0;
                    end else begin
                        w_oi_n = {16'h0, w_word[15:0]};
                        w_oc_n = 1'b1;
                        w_pc_n = w_pc_p2;
                    end
                end else if (r_h_vld) begin
                    w_ov_n = 1'b1;
                    w_oi_n = {w_word[15:0], r_h};
                    w_op_n = r_pc;
                    w_oc_n = 1'b0;
                    w_pc_n = w_pc_p4;
                end
                // else: bubble after a redirect to an odd halfword, H loaded only
            end
        end else if (w_rd_use) begin
            w_s_n  = w_rword;
            w_sv_n = 1'b1;
        end

        if (redirect_valid) begin
            w_pc_n = w_redir_pc;
            w_hv_n = 1'b0;
            w_sv_n = 1'b0;
            w_ov_n = 1'b0;
        end
    end

    // The new target is already in r_pc; discarding the late data is enough
    // to make fetch restart there once the stalled request drains
    assign w_hold_n    = ICACHE_ren && ICACHE_stall;
    assign w_discard_n = w_hold_n && ((r_hold && r_discard) || redirect_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_h         <= 16'h0;
            r_h_vld     <= 1'b0;
            r_s         <= 32'h0;
            r_s_vld     <= 1'b0;
            r_out_vld   <= 1'b0;
            r_out_instr <= 32'h0;
            r_out_pc    <= 32'h0;
            r_out_comp  <= 1'b0;
            r_run       <= 1'b0;
            r_hold      <= 1'b0;
            r_hold_addr <= 30'h0;
            r_discard   <= 1'b0;
        end else begin
            r_pc        <= w_pc_n;
            r_h         <= w_h_n;
            r_h_vld     <= w_hv_n;
            r_s         <= w_s_n;
            r_s_vld     <= w_sv_n;
            r_out_vld   <= w_ov_n;
            r_out_instr <= w_oi_n;
            r_out_pc    <= w_op_n;
            r_out_comp  <= w_oc_n;
            r_run       <= 1'b1;
            r_hold      <= w_hold_n;
            r_hold_addr <= ICACHE_addr;
            r_discard   <= w_discard_n;
        end
    end

endmodule

// File: tb/tb_fetch_align_unit.sv
module tb_fetch_align_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ICACHE_ren, ICACHE_wen;
    logic [29:0] ICACHE_addr;
    logic [31:0] ICACHE_wdata;
    logic        ICACHE_stall = 1'b0;
    logic [31:0] ICACHE_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr, out_pc;
    logic        out_compressed;

    fetch_align_unit #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .ICACHE_ren(ICACHE_ren), .ICACHE_wen(ICACHE_wen),
        .ICACHE_addr(ICACHE_addr), .ICACHE_wdata(ICACHE_wdata),
        .ICACHE_stall(ICACHE_stall), .ICACHE_rdata(ICACHE_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .out_compressed(out_compressed)
    );

    always #5 clk = ~clk;

    // Memory image in instruction order (W); indexed by word address [7:0]
    logic [31:0] mem [256];

    int n_chk = 0;
    int n_err = 0;
    int n_acc = 0;

    int p_stall = 0, p_rdy = 100, p_redir = 0;
    logic        req_redir = 1'b0;
    logic [31:0] req_tgt = 32'h0;

    logic [31:0] m_pc;   // reference: PC of next instruction decode must see

    // previous-cycle observations for protocol checks
    logic        q_ren, q_stall, q_ov, q_rdy, q_redir;
    logic [29:0] q_addr;
    logic [31:0] q_pc, q_instr;
    logic        q_comp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [15:0] half_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic clear_q();
        q_ren = 0; q_stall = 0; q_ov = 0; q_rdy = 0; q_redir = 0;
        q_addr = '0; q_pc = '0; q_instr = '0; q_comp = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
        ICACHE_stall = 1'b0; req_redir = 1'b0;
        @(posedge clk); #1;
        chk("rst_ren_drop", ICACHE_ren, 0);
        @(posedge clk); #1;
        chk("rst_addr", ICACHE_addr, 0);
        chk("rst_ovld", out_valid, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_comp", out_compressed, 0);
        chk("wen_tied", {ICACHE_wen, ICACHE_wdata}, 0);
        rst = 1'b0;
        m_pc = 32'h0;
        clear_q();
    endtask

    // One clock: observe after the edge, then drive inputs for the next edge
    task automatic step();
        logic [15:0] h;
        logic [31:0] e_instr;
        logic        e_comp;
        @(posedge clk); #1;
        if (q_ren && q_stall) begin
            chk("ren_hold", ICACHE_ren, 1);
            chk("addr_hold", ICACHE_addr, q_addr);
        end
        if (q_redir) chk("redir_flush", out_valid, 0);
        else if (q_ov && !q_rdy) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_pc", out_pc, q_pc);
            chk("bp_instr", out_instr, q_instr);
            chk("bp_comp", out_compressed, q_comp);
        end

        out_ready    = ($urandom_range(99) < p_rdy);
        ICACHE_stall = ($urandom_range(99) < p_stall);
        ICACHE_rdata = ICACHE_ren ? swap(mem[ICACHE_addr[7:0]]) : $urandom;
        redirect_valid = 1'b0;
        if (req_redir) begin
            redirect_valid = 1'b1; redirect_pc = req_tgt; req_redir = 1'b0;
        end else if ($urandom_range(99) < p_redir) begin
            redirect_valid = 1'b1;
            redirect_pc = $urandom;
            if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFE0 | (redirect_pc & 32'h1F);
            else redirect_pc = redirect_pc & 32'h3FF;
        end

        if (out_valid && out_ready) begin
            h = half_at(m_pc);
            e_comp  = (h[1:0] != 2'b11);
            e_instr = e_comp ? {16'h0, h} : {half_at(m_pc + 32'd2), h};
            chk("str_pc", out_pc, m_pc);
            chk("str_instr", out_instr, e_instr);
            chk("str_comp", out_compressed, e_comp);
            m_pc = m_pc + (e_comp ? 32'd2 : 32'd4);
            n_acc++;
        end
        if (redirect_valid) m_pc = redirect_pc & 32'hFFFF_FFFE;

        q_ren = ICACHE_ren; q_stall = ICACHE_stall; q_addr = ICACHE_addr;
        q_ov = out_valid; q_rdy = out_ready; q_redir = redirect_valid;
        q_pc = out_pc; q_instr = out_instr; q_comp = out_compressed;
    endtask

    task automatic wait_ren(input string tag);
        for (int i = 0; i < 8 && !ICACHE_ren; i++) step();
        chk(tag, ICACHE_ren, 1);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(1)) w[1:0] = 2'b11; else if (w[1:0] == 2'b11) w[1:0] = 2'b01;
            if ($urandom_range(1)) w[17:16] = 2'b11; else if (w[17:16] == 2'b11) w[17:16] = 2'b10;
            mem[i] = w;
        end
    endtask

    initial begin
        clear_q();
        m_pc = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // T1: aligned 32-bit instructions
        mem[0] = 32'h0050_0093; mem[1] = 32'h0010_0113;
        p_stall = 0; p_rdy = 100; p_redir = 0;
        do_reset();
        wait_ren("t1_ren");
        chk("t1_addr0", ICACHE_addr, 0);
        step();
        chk("t1_vld", out_valid, 1);
        chk("t1_pc0", out_pc, 0);
        chk("t1_instr0", out_instr, 32'h0050_0093);
        chk("t1_comp0", out_compressed, 0);
        chk("t1_addr1", ICACHE_addr, 1);
        step();
        chk("t1_pc4", out_pc, 4);
        chk("t1_instr4", out_instr, 32'h0010_0113);

        // T2: two compressed in one word, second from the buffer
        mem[0] = 32'h4581_4505;
        do_reset();
        wait_ren("t2_ren");
        step();
        chk("t2_pc0", out_pc, 0);
        chk("t2_instr0", out_instr, 32'h0000_4505);
        chk("t2_comp0", out_compressed, 1);
        chk("t2_ren_buf", ICACHE_ren, 0);
        step();
        chk("t2_pc2", out_pc, 2);
        chk("t2_instr2", out_instr, 32'h0000_4581);
        chk("t2_comp2", out_compressed, 1);

        // T3: straddling 32-bit instruction
        mem[0] = 32'h0093_4505; mem[1] = 32'h1234_0050;
        do_reset();
        wait_ren("t3_ren");
        step();
        chk("t3_instr0", out_instr, 32'h0000_4505);
        chk("t3_addr1", ICACHE_addr, 1);
        step();
        chk("t3_pc2", out_pc, 2);
        chk("t3_instr2", out_instr, 32'h0050_0093);
        chk("t3_comp2", out_compressed, 0);
        step();
        chk("t3_pc6", out_pc, 6);
        chk("t3_h6", out_instr, 32'h0000_1234);

        // T4: three stalled cycles on addr 0
        mem[0] = 32'h0050_0093;
        p_stall = 100;
        do_reset();
        wait_ren("t4_ren");
        chk("t4_addr", ICACHE_addr, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t4_ren_st", ICACHE_ren, 1);
            chk("t4_addr_st", ICACHE_addr, 0);
            chk("t4_ovld_st", out_valid, 0);
        end
        p_stall = 0;
        step();
        chk("t4_ovld_last", out_valid, 0);
        step();
        chk("t4_vld", out_valid, 1);
        chk("t4_pc", out_pc, 0);

        // T5: redirect to 0x102 while addr 0 is stalled
        mem[8'h40] = 32'h0093_4505; mem[8'h41] = 32'h0000_0050;
        p_stall = 100;
        do_reset();
        wait_ren("t5_ren");
        req_redir = 1'b1; req_tgt = 32'h0000_0102;
        step();
        chk("t5_hold_ren", ICACHE_ren, 1);
        chk("t5_hold_addr", ICACHE_addr, 0);
        p_stall = 0;
        step();
        chk("t5_hold_addr2", ICACHE_addr, 0);
        step();
        chk("t5_bub_ren", ICACHE_ren, 1);
        chk("t5_bub_addr", ICACHE_addr, 30'h40);
        chk("t5_bub_ovld", out_valid, 0);
        step();
        chk("t5_ovld_gap", out_valid, 0);
        chk("t5_addr41", ICACHE_addr, 30'h41);
        step();
        chk("t5_vld", out_valid, 1);
        chk("t5_pc", out_pc, 32'h102);
        chk("t5_instr", out_instr, 32'h0050_0093);

        // T6: backpressure while a prefetch completes
        for (int i = 0; i < 16; i++) mem[i] = (i << 8) | 32'h13;
        p_stall = 0; p_rdy = 100;
        do_reset();
        wait_ren("t6_ren");
        p_rdy = 0;
        step();
        chk("t6_pc0", out_pc, 0);
        step();
        chk("t6_no_reread", ICACHE_ren, 0);
        p_rdy = 100;
        step();
        chk("t6_no_reread2", ICACHE_ren, 0);
        chk("t6_hold_pc", out_pc, 0);
        step();
        chk("t6_pc4", out_pc, 4);
        step();
        chk("t6_pc8", out_pc, 8);
        for (int i = 0; i < 6; i++) step();

        // T7: reset while a request is stalled (drop checked inside do_reset)
        p_stall = 100;
        do_reset();
        wait_ren("t7_ren");
        step();
        do_reset();

        // Randomised traffic with stalls, backpressure and redirects
        n_acc = 0;
        for (int b = 0; b < 6; b++) begin
            do_reset();
            fill_random();
            p_stall = (b % 3 == 0) ? 0 : ((b % 3 == 1) ? 20 : 50);
            p_rdy   = (b < 2) ? 100 : ((b < 4) ? 60 : 30);
            p_redir = 2;
            for (int i = 0; i < 500; i++) step();
        end
        p_redir = 0;
        chk("progress", (n_acc >= 300), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
